// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// A Moore-style FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
// It waits on mem_ready and halts with a sticky mem_err if memory never answers.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN adds a sticky `illegal` output.
// With that macro, undefined instructions halt instead of retiring as a NOP.
// While rst is high every output reads 0, so a reset mid-instruction writes nothing.
module mc_ctrl #(
  parameter int ALUOP_W     = 4,   // >= 4; bits above [3:0] are driven 0
  parameter int MEM_TIMEOUT = 255  // wait-cycle limit for mem_ready; 0 disables it
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               mem_err
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
    ALU_OR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_NOR = 4'd8, ALU_LUI = 4'd9, ALU_SRL = 4'd10
  } alu_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_RA = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC  = 2'b10;

  // The counter only has to reach MEM_TIMEOUT-1: that wait cycle is the limit cycle.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  // R-type funct to ALU operation; ALU_NOP marks an undefined funct (jr is handled in DECODE).
  function automatic alu_e rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return ALU_ADD;
      6'h22, 6'h23: return ALU_SUB;
      6'h24:        return ALU_AND;
      6'h25:        return ALU_OR;
      6'h27:        return ALU_NOR;
      6'h2A:        return ALU_SLT;
      6'h2B:        return ALU_SLTU;
      6'h00:        return ALU_SLL;
      6'h02:        return ALU_SRL;
      default:      return ALU_NOP;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  alu_e             alu_op;
  logic             waiting;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic instr_legal;

  // Opcode/funct legality, only needed when undefined instructions trap.
  always_comb begin
    instr_legal = 1'b0;
    case (Op)
      OP_RTYPE: instr_legal = (rtype_alu(Funct) != ALU_NOP) || (Funct == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: instr_legal = 1'b1;
      default: instr_legal = 1'b0;
    endcase
  end
`endif

  // Next-state, wait counter and Moore outputs for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wait_d     = '0;
    mem_err_d  = mem_err_q;
    waiting    = 1'b0;
    alu_op     = ALU_NOP;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    EXTOp      = 1'b0;
    ALUSrc     = 1'b0;
    NPCOp      = NPC_PLUS4;
    GPRSel     = GPR_RD;
    WDSel      = WD_ALU;
    instr_done = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (Op == OP_J || Op == OP_JAL) begin
          PCWrite    = 1'b1;
          NPCOp      = NPC_JUMP;
          instr_done = 1'b1;
          state_d    = S_FETCH;
          if (Op == OP_JAL) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
          end
        end else if (Op == OP_RTYPE && Funct == FN_JR) begin
          PCWrite    = 1'b1;
          NPCOp      = NPC_JR;
          instr_done = 1'b1;
          state_d    = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        end else if (!instr_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (Op)
          OP_RTYPE: begin
            alu_op = rtype_alu(Funct);
            if (alu_op == ALU_NOP) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          OP_ADDI: begin EXTOp = 1'b1; ALUSrc = 1'b1; alu_op = ALU_ADD; end
          OP_ORI:  begin ALUSrc = 1'b1; alu_op = ALU_OR;  end
          OP_ANDI: begin ALUSrc = 1'b1; alu_op = ALU_AND; end
          OP_LUI:  begin ALUSrc = 1'b1; alu_op = ALU_LUI; end
          OP_LW, OP_SW: begin
            EXTOp   = 1'b1;
            ALUSrc  = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_op     = ALU_SUB;
            PCWrite    = (Op == OP_BEQ) ? Zero : ~Zero;
            NPCOp      = NPC_BRANCH;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (Op == OP_LW);
        MemWrite = (Op == OP_SW);
        if (mem_ready) begin
          if (Op == OP_LW) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        GPRSel     = (Op == OP_RTYPE) ? GPR_RD : GPR_RT;
        WDSel      = (Op == OP_LW) ? WD_MEM : WD_ALU;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A wait cycle that hits the limit halts; a mem_ready on that cycle never gets here.
    if (waiting) begin
      if (TIMEOUT_EN && wait_q == WAIT_LIMIT) begin
        mem_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end

    ALUOp   = ALUOP_W'(alu_op);
    state   = state_q;
    mem_err = mem_err_q;

    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      EXTOp      = 1'b0;
      ALUSrc     = 1'b0;
      ALUOp      = '0;
      NPCOp      = NPC_PLUS4;
      GPRSel     = GPR_RD;
      WDSel      = WD_ALU;
      instr_done = 1'b0;
      state      = S_FETCH;
      mem_err    = 1'b0;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = illegal_q & ~rst;
`endif

  // State register, wait counter and sticky flags with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values.
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (default build, MEM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are compared 1 ns later as a packed vector:
// {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc,
//  ALUOp[3:0], NPCOp, GPRSel, WDSel, state, instr_done}
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state;
  logic       instr_done, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef logic [21:0] vec_t;

  mc_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
    .instr_done(instr_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Build an expected output vector from hand-written field values.
  function automatic vec_t mk(input int pcw, irw, iord, mrd, mwr, rgw, ext, alus,
                              input int alu, npc, gpr, wd, st, done);
    return {1'(pcw), 1'(irw), 1'(iord), 1'(mrd), 1'(mwr), 1'(rgw), 1'(ext), 1'(alus),
            4'(alu), 2'(npc), 2'(gpr), 2'(wd), 3'(st), 1'(done)};
  endfunction

  function automatic vec_t outs();
    return {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc,
            ALUOp, NPCOp, GPRSel, WDSel, state, instr_done};
  endfunction

  // Advance to the next falling edge, apply inputs, let the combinational outputs settle.
  task automatic cyc(input int r, op, fn, z, rdy);
    @(negedge clk);
    rst = 1'(r); Op = 6'(op); Funct = 6'(fn); Zero = 1'(z); mem_ready = 1'(rdy);
    #1;
  endtask

  localparam int OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5, OP_ADDI = 8;
  localparam int OP_ANDI = 12, OP_LW = 35, OP_SW = 43;

  vec_t v_fetch_ok, v_fetch_wait, v_decode, v_dec_j, v_zero;

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, OP_J, 0, 0, 1);
      n_checks++;
      if (outs() !== v_zero || mem_err !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold c%0d: got %h err=%b expected %h err=0", i, outs(), mem_err, v_zero);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs() !== v_fetch_ok) begin
      n_errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", outs(), v_fetch_ok);
    end
    cyc(0, OP_J, 0, 0, 1);
    n_checks++;
    if (outs() !== v_dec_j) begin
      n_errors++;
      $display("FAIL reset_decode_j: got %h expected %h", outs(), v_dec_j);
    end
  endtask

  task automatic test_add();
    vec_t exp_v[4];
    exp_v = '{v_fetch_ok, v_decode,
              mk(0,0,0,0,0,0,0,0, 1,0,0,0, 2,0),
              mk(0,0,0,0,0,1,0,0, 0,0,0,0, 4,1)};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 'h20, 0, 1);
      n_checks++;
      if (outs() !== exp_v[i]) begin
        n_errors++;
        $display("FAIL add c%0d: got %h expected %h", i, outs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_lw();
    vec_t exp_v[8];
    int   rdy[8];
    exp_v = '{v_fetch_ok, v_decode,
              mk(0,0,0,0,0,0,1,1, 1,0,0,0, 2,0),
              mk(0,0,1,1,0,0,0,0, 0,0,0,0, 3,0),
              mk(0,0,1,1,0,0,0,0, 0,0,0,0, 3,0),
              mk(0,0,1,1,0,0,0,0, 0,0,0,0, 3,0),
              mk(0,0,1,1,0,0,0,0, 0,0,0,0, 3,0),
              mk(0,0,0,0,0,1,0,0, 0,0,1,1, 4,1)};
    rdy = '{1, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(0, OP_LW, 0, 0, rdy[i]);
      n_checks++;
      if (outs() !== exp_v[i]) begin
        n_errors++;
        $display("FAIL lw_wait c%0d: got %h expected %h", i, outs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_sw();
    vec_t exp_v[4];
    exp_v = '{v_fetch_ok, v_decode,
              mk(0,0,0,0,0,0,1,1, 1,0,0,0, 2,0),
              mk(0,0,1,0,1,0,0,0, 0,0,0,0, 3,1)};
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_SW, 0, 0, 1);
      n_checks++;
      if (outs() !== exp_v[i]) begin
        n_errors++;
        $display("FAIL sw c%0d: got %h expected %h", i, outs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_branch();
    int   ops[3], zs[3];
    vec_t exec_v[3];
    vec_t exp_v;
    ops    = '{OP_BEQ, OP_BNE, OP_BNE};
    zs     = '{1, 1, 0};
    exec_v = '{mk(1,0,0,0,0,0,0,0, 2,1,0,0, 2,1),
               mk(0,0,0,0,0,0,0,0, 2,1,0,0, 2,1),
               mk(1,0,0,0,0,0,0,0, 2,1,0,0, 2,1)};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) begin
        cyc(0, ops[b], 0, zs[b], 1);
        exp_v = (i == 0) ? v_fetch_ok : (i == 1) ? v_decode : exec_v[b];
        n_checks++;
        if (outs() !== exp_v) begin
          n_errors++;
          $display("FAIL branch op=%0d zero=%0d c%0d: got %h expected %h", ops[b], zs[b], i, outs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_jal_jr();
    int   ops[2], fns[2];
    vec_t dec_v[2];
    vec_t exp_v;
    ops   = '{OP_JAL, 0};
    fns   = '{0, 8};
    dec_v = '{mk(1,0,0,0,0,1,0,0, 0,2,2,2, 1,1),
              mk(1,0,0,0,0,0,0,0, 0,3,0,0, 1,1)};
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 2; i++) begin
        cyc(0, ops[b], fns[b], 0, 1);
        exp_v = (i == 0) ? v_fetch_ok : dec_v[b];
        n_checks++;
        if (outs() !== exp_v) begin
          n_errors++;
          $display("FAIL jump op=%0d fn=%0d c%0d: got %h expected %h", ops[b], fns[b], i, outs(), exp_v);
        end
      end
    end
  endtask

  // andi, addi and srl: EXEC controls plus the WB register destination.
  task automatic test_alu_ops();
    int   ops[3], fns[3];
    vec_t exec_v[3], wb_v[3];
    vec_t exp_v;
    ops    = '{OP_ANDI, OP_ADDI, 0};
    fns    = '{0, 0, 2};
    exec_v = '{mk(0,0,0,0,0,0,0,1, 3,0,0,0, 2,0),
               mk(0,0,0,0,0,0,1,1, 1,0,0,0, 2,0),
               mk(0,0,0,0,0,0,0,0, 10,0,0,0, 2,0)};
    wb_v   = '{mk(0,0,0,0,0,1,0,0, 0,0,1,0, 4,1),
               mk(0,0,0,0,0,1,0,0, 0,0,1,0, 4,1),
               mk(0,0,0,0,0,1,0,0, 0,0,0,0, 4,1)};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(0, ops[b], fns[b], 0, 1);
        exp_v = (i == 0) ? v_fetch_ok : (i == 1) ? v_decode : (i == 2) ? exec_v[b] : wb_v[b];
        n_checks++;
        if (outs() !== exp_v) begin
          n_errors++;
          $display("FAIL alu_op op=%0d fn=%0d c%0d: got %h expected %h", ops[b], fns[b], i, outs(), exp_v);
        end
      end
    end
  endtask

  // Undefined opcode and undefined R-type funct both retire from EXEC with no writes.
  task automatic test_undef();
    int   ops[2], fns[2];
    vec_t exp_v;
    ops = '{'h3F, 0};
    fns = '{0, 'h3F};
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        cyc(0, ops[b], fns[b], 0, 1);
        exp_v = (i == 0) ? v_fetch_ok : (i == 1) ? v_decode : mk(0,0,0,0,0,0,0,0, 0,0,0,0, 2,1);
        n_checks++;
        if (outs() !== exp_v) begin
          n_errors++;
          $display("FAIL undef op=%0d fn=%0d c%0d: got %h expected %h", ops[b], fns[b], i, outs(), exp_v);
        end
      end
    end
  endtask

  // Reset asserted during an add's EXEC: no writes that cycle, clean FETCH afterwards.
  task automatic test_reset_mid();
    cyc(0, 0, 'h20, 0, 1);
    cyc(0, 0, 'h20, 0, 1);
    cyc(1, 0, 'h20, 0, 1);
    n_checks++;
    if (outs() !== v_zero) begin
      n_errors++;
      $display("FAIL reset_mid_exec: got %h expected %h", outs(), v_zero);
    end
    cyc(0, OP_J, 0, 0, 1);
    n_checks++;
    if (outs() !== v_fetch_ok) begin
      n_errors++;
      $display("FAIL reset_mid_fetch: got %h expected %h", outs(), v_fetch_ok);
    end
    cyc(0, OP_J, 0, 0, 1);
    n_checks++;
    if (outs() !== v_dec_j) begin
      n_errors++;
      $display("FAIL reset_mid_decode: got %h expected %h", outs(), v_dec_j);
    end
  endtask

  task automatic test_timeout();
    vec_t v_halt;
    vec_t exp_v;
    int   rdy[4];
    v_halt = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 5,0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_J, 0, 0, 0);
      n_checks++;
      if (outs() !== v_fetch_wait || mem_err !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_wait c%0d: got %h err=%b expected %h err=0", i, outs(), mem_err, v_fetch_wait);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, OP_J, 0, 0, i);
      n_checks++;
      if (outs() !== v_halt || mem_err !== 1'b1) begin
        n_errors++;
        $display("FAIL timeout_halt c%0d: got %h err=%b expected %h err=1", i, outs(), mem_err, v_halt);
      end
    end
    cyc(1, OP_J, 0, 0, 0);
    n_checks++;
    if (outs() !== v_zero || mem_err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_reset: got %h err=%b expected %h err=0", outs(), mem_err, v_zero);
    end
    // mem_ready on the fourth wait cycle (the limit cycle) completes the fetch.
    rdy = '{0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cyc(0, OP_J, 0, 0, (i < 4) ? rdy[i] : 1);
      exp_v = (i < 3) ? v_fetch_wait : (i == 3) ? v_fetch_ok : v_dec_j;
      n_checks++;
      if (outs() !== exp_v || mem_err !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_edge c%0d: got %h err=%b expected %h err=0", i, outs(), mem_err, exp_v);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    v_fetch_ok   = mk(1,1,0,1,0,0,0,0, 0,0,0,0, 0,0);
    v_fetch_wait = mk(0,0,0,1,0,0,0,0, 0,0,0,0, 0,0);
    v_decode     = mk(0,0,0,0,0,0,0,0, 0,0,0,0, 1,0);
    v_dec_j      = mk(1,0,0,0,0,0,0,0, 0,2,0,0, 1,1);
    v_zero       = '0;
    rst = 1'b1; Op = 6'(OP_J); Funct = '0; Zero = 1'b0; mem_ready = 1'b1;

    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch();
    test_jal_jr();
    test_alu_ops();
    test_undef();
    test_reset_mid();
    test_timeout();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
